// File: rtl/iic_pkg.sv
// Shared I2C definitions: target FSM states, default device address, ACK level.
`timescale 1ns/1ps
package iic_pkg;
  localparam logic [6:0] ADV7511_ADDR = 7'h76;
  localparam logic       IIC_ACK      = 1'b0;

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, REG, REG_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE
  } iic_tgt_state_t;
endpackage

// File: rtl/iic_sync_edge.sv
// Two-flop synchronizer plus history flop; flags rising/falling edges of a pin.
// Resets to 1 because both I2C lines idle high.
`timescale 1ns/1ps
module iic_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);
  logic [2:0] sh_q, sh_d;

  assign sh_d  = {sh_q[1:0], din};
  assign level = sh_q[1];
  assign rise  = sh_q[1] & ~sh_q[2];
  assign fall  = ~sh_q[1] & sh_q[2];

  // synchronizer stages [1:0], history stage [2]
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sh_q <= 3'b111;
    else     sh_q <= sh_d;
  end
endmodule

// File: rtl/iic_target.sv
// I2C target with a 256x8 register file and auto-incrementing pointer.
// Define IIC_TARGET_READ_EN to compile in the read path (RDATA/RDATA_ACK).
`timescale 1ns/1ps
module iic_target
  import iic_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR = ADV7511_ADDR,
  parameter logic [7:0] RST_VALUE  = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic       wr_valid,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       busy,
  input  logic [7:0] dbg_addr,
  output logic [7:0] dbg_data
);
  logic scl_lvl, scl_rise, scl_fall;
  logic sda_lvl, sda_rise, sda_fall;

  iic_sync_edge u_scl (.clk(clk), .rst(rst), .din(scl_in), .level(scl_lvl), .rise(scl_rise), .fall(scl_fall));
  iic_sync_edge u_sda (.clk(clk), .rst(rst), .din(sda_in), .level(sda_lvl), .rise(sda_rise), .fall(sda_fall));

  // an SCL edge in the same cycle suppresses START/STOP
  logic scl_quiet, start_det, stop_det;
  assign scl_quiet = ~scl_rise & ~scl_fall;
  assign start_det = sda_fall & scl_lvl & scl_quiet;
  assign stop_det  = sda_rise & scl_lvl & scl_quiet;

  iic_tgt_state_t state_q, state_d;
  logic [3:0] bitcnt_q, bitcnt_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] ptr_q, ptr_d;
  logic       sda_oe_q, sda_oe_d;
  logic       busy_q, busy_d;
  logic       wr_valid_q, wr_valid_d;
  logic [7:0] wr_addr_q, wr_addr_d;
  logic [7:0] wr_data_q, wr_data_d;
  logic [7:0] rx_byte;
  logic [7:0] mem_q [256];
`ifdef IIC_TARGET_READ_EN
  logic [7:0] tx_q, tx_d;
`endif

  // next-state: byte framing, ACK slots, pointer and register-file writes
  always_comb begin
    state_d    = state_q;
    bitcnt_d   = bitcnt_q;
    shift_d    = shift_q;
    ptr_d      = ptr_q;
    sda_oe_d   = sda_oe_q;
    busy_d     = busy_q;
    wr_valid_d = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
`ifdef IIC_TARGET_READ_EN
    tx_d       = tx_q;
`endif
    rx_byte    = {shift_q[6:0], sda_lvl};
    if (start_det) begin
      state_d  = ADDR;
      bitcnt_d = 4'd0;
      sda_oe_d = 1'b0;
      busy_d   = 1'b1;
    end else if (stop_det) begin
      state_d  = IDLE;
      bitcnt_d = 4'd0;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
    end else begin
      case (state_q)
        ADDR, REG, WDATA: if (scl_rise) begin
          shift_d  = rx_byte;
          bitcnt_d = bitcnt_q + 4'd1;
          if (bitcnt_q == 4'd7) begin
            bitcnt_d = 4'd0;
            case (state_q)
              ADDR: begin
                if (rx_byte[7:1] != SLAVE_ADDR) state_d = IGNORE;
`ifdef IIC_TARGET_READ_EN
                else                            state_d = ADDR_ACK;
`else
                else if (rx_byte[0])            state_d = IGNORE;
                else                            state_d = ADDR_ACK;
`endif
              end
              REG: begin
                ptr_d   = rx_byte;
                state_d = REG_ACK;
              end
              default: begin
                wr_valid_d = 1'b1;
                wr_addr_d  = ptr_q;
                wr_data_d  = rx_byte;
                ptr_d      = ptr_q + 8'd1;
                state_d    = WDATA_ACK;
              end
            endcase
          end
        end
        // first fall after the 8th bit pulls SDA, the next one releases it
        ADDR_ACK, REG_ACK, WDATA_ACK: if (scl_fall) begin
          if (!sda_oe_q) begin
            sda_oe_d = (IIC_ACK == 1'b0);
          end else begin
            sda_oe_d = 1'b0;
            bitcnt_d = 4'd0;
            state_d  = WDATA;
            if (state_q == ADDR_ACK) state_d = REG;
`ifdef IIC_TARGET_READ_EN
            if (state_q == ADDR_ACK && shift_q[0]) begin
              tx_d     = mem_q[ptr_q];
              sda_oe_d = ~mem_q[ptr_q][7];
              state_d  = RDATA;
            end
`endif
          end
        end
`ifdef IIC_TARGET_READ_EN
        RDATA: begin
          if (scl_rise) bitcnt_d = bitcnt_q + 4'd1;
          else if (scl_fall) begin
            if (bitcnt_q == 4'd8) begin
              sda_oe_d = 1'b0;
              bitcnt_d = 4'd0;
              state_d  = RDATA_ACK;
            end else begin
              tx_d     = {tx_q[6:0], 1'b0};
              sda_oe_d = ~tx_q[6];
            end
          end
        end
        // bitcnt==1 marks a master ACK seen; the following fall starts the next byte
        RDATA_ACK: begin
          if (scl_rise) begin
            if (sda_lvl == IIC_ACK) begin
              ptr_d    = ptr_q + 8'd1;
              bitcnt_d = 4'd1;
            end else begin
              state_d  = IGNORE;
            end
          end else if (scl_fall && bitcnt_q == 4'd1) begin
            tx_d     = mem_q[ptr_q];
            sda_oe_d = ~mem_q[ptr_q][7];
            bitcnt_d = 4'd0;
            state_d  = RDATA;
          end
        end
`endif
        default: ;
      endcase
    end
  end

  // state and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      bitcnt_q   <= 4'd0;
      shift_q    <= 8'h00;
      ptr_q      <= 8'h00;
      sda_oe_q   <= 1'b0;
      busy_q     <= 1'b0;
      wr_valid_q <= 1'b0;
      wr_addr_q  <= 8'h00;
      wr_data_q  <= 8'h00;
`ifdef IIC_TARGET_READ_EN
      tx_q       <= 8'h00;
`endif
    end else begin
      state_q    <= state_d;
      bitcnt_q   <= bitcnt_d;
      shift_q    <= shift_d;
      ptr_q      <= ptr_d;
      sda_oe_q   <= sda_oe_d;
      busy_q     <= busy_d;
      wr_valid_q <= wr_valid_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
`ifdef IIC_TARGET_READ_EN
      tx_q       <= tx_d;
`endif
    end
  end

  // register file, written in the same cycle wr_valid goes high
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) mem_q[i] <= RST_VALUE;
    end else if (wr_valid_d) begin
      mem_q[wr_addr_d] <= wr_data_d;
    end
  end

  assign sda_oe   = sda_oe_q;
  assign busy     = busy_q;
  assign wr_valid = wr_valid_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;
  assign dbg_data = mem_q[dbg_addr];
endmodule

// File: tb/tb_iic_target.sv
// Self-checking bench for iic_target: a bit-banged I2C master on an open-drain SDA.
`timescale 1ns/1ps
module tb_iic_target;
  localparam int Q = 8;

  logic       clk = 1'b0, rst = 1'b1;
  logic       scl_m = 1'b1, sda_m = 1'b1;
  logic       sda_in, sda_oe, wr_valid, busy;
  logic [7:0] wr_addr, wr_data, dbg_addr = 8'h00, dbg_data;

  assign sda_in = sda_m & ~sda_oe;

  iic_target dut (
    .clk(clk), .rst(rst), .scl_in(scl_m), .sda_in(sda_in), .sda_oe(sda_oe),
    .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;
  int wr_cnt = 0;
  logic [7:0] last_a = 8'h00, last_d = 8'h00;
  logic [7:0] exp_mem [256];

  // counts every cycle wr_valid is high, so a stretched pulse shows up as an extra count
  always @(negedge clk) if (wr_valid) begin
    wr_cnt++;
    last_a = wr_addr;
    last_d = wr_data;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic wait_q();
    repeat (Q) @(negedge clk);
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; wait_q();
    scl_m = 1'b1; wait_q();
    sda_m = 1'b0; wait_q();
    scl_m = 1'b0; wait_q();
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; wait_q();
    scl_m = 1'b1; wait_q();
    sda_m = 1'b1; wait_q();
  endtask

  task automatic send_bits(input logic [7:0] b, input int n);
    for (int i = 7; i > 7 - n; i--) begin
      sda_m = b[i]; wait_q();
      scl_m = 1'b1; wait_q();
      scl_m = 1'b0; wait_q();
    end
  endtask

  // ack is the bus level during the 9th clock: 0 = acknowledged
  task automatic send_byte(input logic [7:0] b, output logic ack);
    send_bits(b, 8);
    sda_m = 1'b1; wait_q();
    scl_m = 1'b1; repeat (Q/2) @(negedge clk);
    ack = sda_in; repeat (Q/2) @(negedge clk);
    scl_m = 1'b0; wait_q();
  endtask

  task automatic recv_byte(output logic [7:0] b, input logic mack);
    for (int i = 7; i >= 0; i--) begin
      sda_m = 1'b1; wait_q();
      scl_m = 1'b1; repeat (Q/2) @(negedge clk);
      b[i] = sda_in; repeat (Q/2) @(negedge clk);
      scl_m = 1'b0; wait_q();
    end
    sda_m = mack; wait_q();
    scl_m = 1'b1; wait_q();
    scl_m = 1'b0; wait_q();
  endtask

  task automatic rd_dbg(input logic [7:0] a, input string nm);
    dbg_addr = a; #1;
    chk(nm, dbg_data, exp_mem[a]);
  endtask

  typedef struct {
    logic [6:0] dev;
    logic [7:0] rg;
    logic [7:0] dat;
    logic       acked;
  } vec_t;

  vec_t vt [5];
  logic ack;
  logic [7:0] rb;
  int n0;

  initial begin
    for (int i = 0; i < 256; i++) exp_mem[i] = 8'h00;
    vt[0] = '{7'h76, 8'h0A, 8'h10, 1'b1};
    vt[1] = '{7'h76, 8'h00, 8'hFF, 1'b1};
    vt[2] = '{7'h76, 8'h80, 8'h5C, 1'b1};
    vt[3] = '{7'h39, 8'h0B, 8'h77, 1'b0};
    vt[4] = '{7'h77, 8'h0C, 8'h66, 1'b0};

    // reset state
    repeat (4) @(negedge clk);
    chk("rst_sda_oe", sda_oe, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    chk("rst_wr_valid", wr_valid, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_busy_after", busy, 0);
    rd_dbg(8'h00, "rst_mem00");
    rd_dbg(8'h5A, "rst_mem5a");

    // single-byte writes, matching and non-matching addresses
    for (int v = 0; v < 5; v++) begin
      n0 = wr_cnt;
      i2c_start();
      chk($sformatf("v%0d_busy", v), busy, 1);
      send_byte({vt[v].dev, 1'b0}, ack);
      chk($sformatf("v%0d_addr_ack", v), ack, !vt[v].acked);
      send_byte(vt[v].rg, ack);
      chk($sformatf("v%0d_reg_ack", v), ack, !vt[v].acked);
      send_byte(vt[v].dat, ack);
      chk($sformatf("v%0d_dat_ack", v), ack, !vt[v].acked);
      chk($sformatf("v%0d_busy_mid", v), busy, 1);
      i2c_stop();
      chk($sformatf("v%0d_busy_end", v), busy, 0);
      chk($sformatf("v%0d_wr_cnt", v), wr_cnt - n0, vt[v].acked ? 1 : 0);
      if (vt[v].acked) begin
        exp_mem[vt[v].rg] = vt[v].dat;
        chk($sformatf("v%0d_wr_addr", v), last_a, vt[v].rg);
        chk($sformatf("v%0d_wr_data", v), last_d, vt[v].dat);
      end
      rd_dbg(vt[v].rg, $sformatf("v%0d_dbg", v));
    end

    // burst write across the pointer wrap
    n0 = wr_cnt;
    i2c_start();
    send_byte(8'hEC, ack); chk("wrap_addr_ack", ack, 0);
    send_byte(8'hFE, ack); chk("wrap_reg_ack", ack, 0);
    send_byte(8'h11, ack); chk("wrap_d0_ack", ack, 0);
    send_byte(8'h22, ack); chk("wrap_d1_ack", ack, 0);
    send_byte(8'h33, ack); chk("wrap_d2_ack", ack, 0);
    chk("wrap_last_addr", last_a, 8'h00);
    i2c_stop();
    exp_mem[8'hFE] = 8'h11; exp_mem[8'hFF] = 8'h22; exp_mem[8'h00] = 8'h33;
    chk("wrap_wr_cnt", wr_cnt - n0, 3);
    rd_dbg(8'hFE, "wrap_memfe");
    rd_dbg(8'hFF, "wrap_memff");
    rd_dbg(8'h00, "wrap_mem00");

`ifdef IIC_TARGET_READ_EN
    // prefill 14h/15h, then read them back through a repeated START
    i2c_start();
    send_byte(8'hEC, ack); send_byte(8'h14, ack);
    send_byte(8'hA5, ack); send_byte(8'h5A, ack);
    i2c_stop();
    exp_mem[8'h14] = 8'hA5; exp_mem[8'h15] = 8'h5A;
    i2c_start();
    send_byte(8'hEC, ack); chk("rd_waddr_ack", ack, 0);
    send_byte(8'h14, ack); chk("rd_reg_ack", ack, 0);
    i2c_start();
    send_byte(8'hED, ack); chk("rd_raddr_ack", ack, 0);
    recv_byte(rb, 1'b0);   chk("rd_byte0", rb, exp_mem[8'h14]);
    recv_byte(rb, 1'b1);   chk("rd_byte1", rb, exp_mem[8'h15]);
    chk("rd_released", sda_oe, 0);
    i2c_stop();
    chk("rd_busy_end", busy, 0);
`else
    // read request without the read path: NACK and stay off the bus
    i2c_start();
    send_byte(8'hED, ack); chk("nord_addr_nack", ack, 1);
    send_byte(8'h00, ack); chk("nord_ignore_nack", ack, 1);
    chk("nord_busy", busy, 1);
    i2c_stop();
    chk("nord_busy_end", busy, 0);
`endif

    // reset mid-data-byte: no write, busy drops at once
    n0 = wr_cnt;
    i2c_start();
    send_byte(8'hEC, ack);
    send_byte(8'h30, ack);
    send_bits(8'hC3, 4);
    @(negedge clk); rst = 1'b1; #1;
    chk("rstmid_busy", busy, 0);
    chk("rstmid_oe", sda_oe, 0);
    repeat (4) @(negedge clk); rst = 1'b0;
    for (int i = 0; i < 256; i++) exp_mem[i] = 8'h00;
    chk("rstmid_wr_cnt", wr_cnt - n0, 0);
    rd_dbg(8'hFE, "rstmid_memfe");

    // reset while the target is driving ACK releases SDA asynchronously
    i2c_start();
    send_bits(8'hEC, 8);
    wait_q();
    chk("rstack_oe_on", sda_oe, 1);
    @(negedge clk); rst = 1'b1; #1;
    chk("rstack_oe_off", sda_oe, 0);
    repeat (4) @(negedge clk); rst = 1'b0;
    repeat (4) @(negedge clk);

    // next full transaction after reset
    n0 = wr_cnt;
    i2c_start();
    send_byte(8'hEC, ack); chk("post_addr_ack", ack, 0);
    send_byte(8'h31, ack); chk("post_reg_ack", ack, 0);
    send_byte(8'h9E, ack); chk("post_dat_ack", ack, 0);
    i2c_stop();
    exp_mem[8'h31] = 8'h9E;
    chk("post_wr_cnt", wr_cnt - n0, 1);
    chk("post_wr_addr", last_a, 8'h31);
    rd_dbg(8'h31, "post_mem31");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/iic_target.md
# iic_target

I2C target (responder) for the two-wire configuration bus. It is the other end of the configuration master. The target decodes START and STOP conditions, matches its 7-bit address, and acknowledges. It then writes or reads an internal 256×8 register file through an auto-incrementing pointer. In simulation it stands in for the ADV7511 so benches can check the programmed register values; in hardware it serves as a debug register target.

## Interface
- SLAVE_ADDR, 7'h76, 7-bit address this target responds to
- RST_VALUE, 8'h00, reset contents of every register-file entry
- clk  input  1  system clock; must run at least 8× the SCL rate
- rst  input  1  reset: asynchronous, active-high. Clock: clk.
- scl_in  input  1  raw SCL pin level, asynchronous to clk
- sda_in  input  1  raw SDA pin level, asynchronous to clk
- sda_oe  output  1  1 = pull SDA low (open-drain); 0 = release
- wr_valid  output  1  one-cycle pulse when a data byte is committed to the register file
- wr_addr  output  8  register address of the committed byte; valid while wr_valid is high
- wr_data  output  8  committed byte; valid while wr_valid is high
- busy  output  1  high from a detected START until a detected STOP
- dbg_addr  input  8  host-side read address
- dbg_data  output  8  register file entry at dbg_addr, combinational

## Operation
- Input conditioning: scl_in and sda_in each pass through a 2-flop synchronizer plus one history flop. Edges are detected on the synchronized values.
- START: SDA falls while SCL is high. STOP: SDA rises while SCL is high.
- Bits are sampled on SCL rising edges. sda_oe changes only on SCL falling edges.
- States (iic_tgt_state_t):
  - IDLE, ADDR, ADDR_ACK, REG, REG_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE.
- Transitions:
  - START from any state → ADDR, clearing the bit counter. This covers repeated START.
  - STOP from any state → IDLE, with sda_oe released.
  - ADDR: after 8 bits, compare the 7 address bits to SLAVE_ADDR.
    - Address match → ADDR_ACK.
    - Mismatch → IGNORE, which holds until the next START or STOP.
  - ADDR_ACK: drive ACK.
    - R/W = 0 → REG.
    - R/W = 1 → RDATA.
  - REG: 8 bits load the pointer → REG_ACK → WDATA.
  - WDATA: 8 bits are written to reg[ptr], wr_valid pulses, and ptr increments → WDATA_ACK → WDATA.
  - RDATA: shift out reg[ptr] MSB first, driving sda_oe = ~bit → RDATA_ACK (sda_oe released).
    - Master ACK (SDA = 0) → ptr+1, then RDATA.
    - Master NACK (SDA = 1) → IGNORE.
- ACK generation: sda_oe is asserted at the SCL falling edge after the 8th bit. It is released at the next SCL falling edge.
- Pointer arithmetic: 8-bit, wraps 8'hFF → 8'h00 with no error.
- A START or STOP inside a byte discards that partial byte. No write occurs.

## Timing
- Reset values:
  - sda_oe = 0, wr_valid = 0, wr_addr = 0, wr_data = 0, busy = 0.
  - ptr = 0, state = IDLE, all registers = RST_VALUE.
- Reset asserted mid-transaction releases SDA immediately. The target then ignores the bus until the next START.
- Detection latency: a pin edge is detected 3 clk cycles after it occurs, through the synchronizer and history flop.
- wr_valid is high for exactly 1 cycle, in the clk cycle after detection of the 8th WDATA rising edge. The register file updates on the same edge.
- sda_oe updates in the cycle after a SCL falling edge is detected, well inside the SCL low phase.
- busy rises the cycle after START is detected and falls the cycle after STOP is detected.
- Simultaneous SCL and SDA edges in the same detection cycle: the SCL edge wins, and no START or STOP is flagged.

## Configuration
- IIC_TARGET_READ_EN defined: the read path (RDATA, RDATA_ACK) is compiled in.
- Undefined:
  - R/W = 1 with a matching address is not ACKed and goes → IGNORE.
  - The RDATA and RDATA_ACK states and the output shift register are absent.

## Structure
- Shared package iic_pkg:
  - iic_tgt_state_t enum.
  - ADV7511_ADDR = 7'h76.
  - IIC_ACK = 1'b0 (bus level).
- Sub-module iic_sync_edge: 2-flop synchronizer plus rise/fall detect. Instantiated once for SCL and once for SDA.
- The register file is a plain 256×8 array inside iic_target.

## Test plan
- Write 76h/W, reg 0Ah, data 10h, STOP → ACKs at all 3 ACK slots; wr_valid ×1 with wr_addr = 0Ah, wr_data = 10h; dbg_addr = 0Ah reads 10h.
- Burst write reg FEh with data 11h, 22h, 33h → entries FEh = 11h, FFh = 22h, 00h = 33h (pointer wrap).
- Address 39h → no ACK and no write; busy stays high until STOP, then 0.
- With READ_EN: write ptr 14h, repeated START, 76h/R, read 2 bytes with ACK then NACK → the bus returns reg[14h] and reg[15h]; SDA is released after the NACK.
- rst pulsed mid-data-byte → sda_oe = 0 and busy = 0 immediately; the next full write transaction succeeds.
- Without READ_EN: 76h/R → NACK; state IGNORE until STOP.
